// File: rtl/sm3_pkg.sv
// Shared SM3 constants and the padder state type.
package sm3_pkg;

    localparam int unsigned SM3_BLOCK_W     = 512;
    localparam int unsigned SM3_HASH_W      = 256;
    localparam int unsigned SM3_BLOCK_BYTES = SM3_BLOCK_W / 8;
    localparam int unsigned SM3_LEN_OFF     = 56;

    localparam logic [SM3_HASH_W-1:0] SM3_IV =
        256'h7380166F_4914B2B9_172442D7_DA8A0600_A96F30BC_163138AA_E38DEE4D_B0FB0E4E;

    localparam logic [7:0] SM3_PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        OUT   = 2'd1,
        EXTRA = 2'd2
    } sm3_pad_state_e;

endpackage

// File: rtl/sm3_pad_tail.sv
// Combinational tail builder: keeps cnt_i message bytes, appends 0x80 and,
// when it fits, the 64-bit big-endian bit length in bytes 56..63.
module sm3_pad_tail
    import sm3_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic [SM3_BLOCK_W-1:0] blk_i,
    input  logic [6:0]             cnt_i,
    input  logic [LEN_W-1:0]       len_i,
    output logic [SM3_BLOCK_W-1:0] block_c,
    output logic                   need_extra_c,
    output logic                   has80_c
);

    logic [63:0] len64;

    always_comb begin
        len64        = 64'(len_i);
        block_c      = '0;
        need_extra_c = (cnt_i >= 7'(SM3_LEN_OFF));
        has80_c      = (cnt_i == 7'(SM3_BLOCK_BYTES));
        for (int k = 0; k < 64; k++) begin
            if (7'(k) < cnt_i) begin
                block_c[511-8*k -: 8] = blk_i[511-8*k -: 8];
            end else if (7'(k) == cnt_i) begin
                block_c[511-8*k -: 8] = SM3_PAD_BYTE;
            end
        end
        // Length only lands here when the 0x80 byte left bytes 56..63 free.
        if (!need_extra_c) begin
            block_c[63:0] = len64;
        end
    end

endmodule

// File: rtl/sm3_pad.sv
// SM3 message padder: byte stream in, padded 512-bit blocks out, one buffer.
module sm3_pad
    import sm3_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_keep,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SM3_BLOCK_W-1:0] out_block,
    output logic                   out_last
);

    localparam int unsigned PTR_W = 6;
    localparam int unsigned CNT_W = 7;

    sm3_pad_state_e         state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [SM3_BLOCK_W-1:0] data_q, data_d;
    logic                   extra_pend_q, extra_pend_d;
    logic                   extra_has80_q, extra_has80_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   in_ready_q, in_ready_d;

    logic [SM3_BLOCK_W-1:0] data_wr;
    logic [CNT_W-1:0]       cnt;
    logic [LEN_W-1:0]       len_nx;
    logic [SM3_BLOCK_W-1:0] tail_blk;
    logic [CNT_W-1:0]       tail_cnt;
    logic [LEN_W-1:0]       tail_len;
    logic [SM3_BLOCK_W-1:0] tail_block;
    logic                   tail_need_extra;
    logic                   tail_has80;

    // Buffer with the current beat's byte merged in at ptr.
    always_comb begin
        data_wr = data_q;
        for (int k = 0; k < 64; k++) begin
            if (in_keep && (PTR_W'(k) == ptr_q)) begin
                data_wr[511-8*k -: 8] = in_data;
            end
        end
        cnt    = CNT_W'(ptr_q) + CNT_W'(in_keep);
        len_nx = len_q + (in_keep ? LEN_W'(8) : LEN_W'(0));
    end

    // One tail builder shared by the last-beat block and the extra block.
    always_comb begin
        if (state_q == EXTRA) begin
            tail_blk = '0;
            tail_cnt = '0;
            tail_len = len_q;
        end else begin
            tail_blk = data_wr;
            tail_cnt = cnt;
            tail_len = len_nx;
        end
    end

    sm3_pad_tail #(
        .LEN_W (LEN_W)
    ) u_tail (
        .blk_i        (tail_blk),
        .cnt_i        (tail_cnt),
        .len_i        (tail_len),
        .block_c      (tail_block),
        .need_extra_c (tail_need_extra),
        .has80_c      (tail_has80)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        len_d         = len_q;
        data_d        = data_q;
        extra_pend_d  = extra_pend_q;
        extra_has80_d = extra_has80_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        in_ready_d    = in_ready_q;

        unique case (state_q)
            FILL: begin
                // A keep=0 beat without last carries nothing and is dropped.
                if (in_valid && in_ready_q && (in_keep || in_last)) begin
                    ptr_d  = ptr_q + PTR_W'(in_keep);
                    len_d  = len_nx;
                    data_d = data_wr;
                    if (in_last) begin
                        data_d        = tail_block;
                        state_d       = OUT;
                        out_valid_d   = 1'b1;
                        in_ready_d    = 1'b0;
                        out_last_d    = ~tail_need_extra;
                        extra_pend_d  = tail_need_extra;
                        extra_has80_d = tail_has80;
                    end else if (cnt == CNT_W'(SM3_BLOCK_BYTES)) begin
                        state_d     = OUT;
                        out_valid_d = 1'b1;
                        in_ready_d  = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (extra_pend_q) begin
                        state_d = EXTRA;
                    end else begin
                        state_d    = FILL;
                        data_d     = '0;
                        ptr_d      = '0;
                        in_ready_d = 1'b1;
                        out_last_d = 1'b0;
                        if (out_last_q) begin
                            len_d = '0;
                        end
                    end
                end
            end
            EXTRA: begin
                data_d = tail_block;
                if (!extra_has80_q) begin
                    data_d[511:504] = 8'h00;
                end
                state_d      = OUT;
                out_valid_d  = 1'b1;
                out_last_d   = 1'b1;
                extra_pend_d = 1'b0;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            ptr_q         <= '0;
            len_q         <= '0;
            data_q        <= '0;
            extra_pend_q  <= 1'b0;
            extra_has80_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            in_ready_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            len_q         <= len_d;
            data_q        <= data_d;
            extra_pend_q  <= extra_pend_d;
            extra_has80_q <= extra_has80_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_block = data_q;
    assign out_last  = out_last_q;

endmodule
